mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback stage; sits directly downstream of the memory stage.
//  Captures memory/ALU results when memory_done is high and returns the mem_wb_pipeline_valid acknowledge.
//  Selects the writeback value and drives the single register-file write port.
//  Exposes a forwarding tap and an ecall retire pulse.
// PARAMETERS
//  XLEN          64   datapath width
//  REG_ADDR_W    5    register index width
//  ECALL_ID      57   control_signals.instruction code for ecall
//  PC_STEP       4    link-address increment for jal/jalr
// PORTS
//  clk              in   1          clock
//  reset            in   1          synchronous, active-high
//  memory_done      in   1          memory stage result ready; held until acknowledged
//  flush            in   1          squash: drop capture, abort commit
//  loaded_data      in   XLEN       load result, already extended
//  alu_data         in   XLEN       ALU result
//  pc               in   XLEN       PC of the instruction in MEM
//  dest_reg         in   REG_ADDR_W destination register
//  reg_write        in   1          instruction writes rd
//  wb_sel           in   2          0=ALU 1=MEM 2=PC+PC_STEP 3=reserved(ALU)
//  instruction      in   8          decoded instruction id
//  mem_wb_pipeline_valid out 1      latched-result acknowledge to memory stage
//  rf_we            out  1          register-file write enable (1-cycle pulse)
//  rf_waddr         out  REG_ADDR_W write index
//  rf_wdata         out  XLEN       write data
//  fwd_valid        out  1          fwd_rd/fwd_data hold a pending or committed result
//  fwd_rd           out  REG_ADDR_W forwarded register index
//  fwd_data         out  XLEN       forwarded value
//  ecall_retire     out  1          1-cycle pulse when an ecall commits
//  wb_busy          out  1          state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; captured registers 0. Reset mid-commit aborts, no rf write.
//  FSM: IDLE -> COMMIT -> DRAIN -> IDLE.
//   IDLE: memory_done & !flush -> capture wb value, dest_reg, reg_write, instruction; go COMMIT.
//   COMMIT (1 cycle): mem_wb_pipeline_valid=1; rf_we=reg_write & (dest_reg!=0);
//     ecall_retire=(instruction==ECALL_ID); go DRAIN.
//   DRAIN: mem_wb_pipeline_valid=1 while memory_done=1; at memory_done=0, valid=0 and go IDLE.
//  Capture-to-rf_we latency: exactly 1 cycle. Minimum spacing between commits: 3 cycles.
//  Writeback value: computed at capture. wb_sel=2 -> pc+PC_STEP mod 2^XLEN (wraps silently).
//  x0: rf_we never asserted for dest_reg==0; fwd_valid also forced 0.
//  flush: in IDLE blocks capture; in COMMIT suppresses rf_we/ecall_retire but still acks and drains.
//    Flush in DRAIN has no effect.
//  memory_done low in IDLE: stay IDLE, outputs 0. memory_done dropping during COMMIT: DRAIN exits next cycle.
//  Forward: fwd_* valid in COMMIT and DRAIN from the captured registers.
//  All outputs registered except rf_*, which decode the state register.
// CONFIGURATION
//  MEM_WB_RETIRE_CNT_EN defined: adds output instret (XLEN). Reset 0.
//    Increments by 1 on each COMMIT not suppressed by flush (includes x0 and non-writing instructions).
//    Wraps at 2^XLEN.
//  Undefined: no instret port, no counter logic.
// STRUCTURE
//  Shared package core_pkg gains:
//    wb_sel_e (WB_ALU, WB_MEM, WB_PC4, WB_RSVD)
//    mem_wb_state_e (IDLE, COMMIT, DRAIN)
//    ECALL_ID constant, shared with the memory stage.
//  One sub-module wb_result_mux: combinational select of alu/loaded/pc+PC_STEP by wb_sel.
// TESTING
//  1. ALU op: alu_data=0x2A, dest_reg=5, wb_sel=0, memory_done 1 for 2 cycles
//     -> rf_we pulse 1 cycle after capture, rf_waddr=5, rf_wdata=0x2A; valid high 2 cycles.
//  2. Load: loaded_data=0xFFFF_FFFF_FFFF_FF80, wb_sel=1, dest_reg=10
//     -> rf_wdata=0xFFFF_FFFF_FFFF_FF80; no second write while memory_done held.
//  3. x0 / jal: dest_reg=0 -> rf_we stays 0, fwd_valid 0.
//     pc=0xFFFF_FFFF_FFFF_FFFC, wb_sel=2, dest_reg=1 -> rf_wdata=0x0.
//  4. Flush: flush=1 in COMMIT -> rf_we=0, ack still issued, state back to IDLE after memory_done drops.
//  5. Ecall: instruction=57, reg_write=0 -> ecall_retire 1-cycle pulse, rf_we=0.
//  6. Reset asserted in COMMIT -> next cycle all outputs 0, no rf write.
//     With MEM_WB_RETIRE_CNT_EN: 3 commits -> instret=3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core package: writeback select encoding, MEM/WB stage states and
// the ecall instruction id that the memory stage also uses.
package core_pkg;

  localparam int XLEN_DEFAULT       = 64;
  localparam int REG_ADDR_W_DEFAULT = 5;
  localparam int PC_STEP_DEFAULT    = 4;

  // Decoded instruction id of ecall, shared with the memory stage.
  localparam logic [7:0] ECALL_ID = 8'd57;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DRAIN  = 2'd2
  } mem_wb_state_e;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback value select: ALU result, load result or link address (pc + step).
// The reserved select code falls back to the ALU result.
module wb_result_mux #(
  parameter int XLEN    = core_pkg::XLEN_DEFAULT,
  parameter int PC_STEP = core_pkg::PC_STEP_DEFAULT
) (
  input  logic [1:0]      wb_sel,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] loaded_data,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] wb_value
);
  import core_pkg::*;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  // Pick the writeback source; the link address wraps silently at 2^XLEN.
  always_comb begin
    wb_value = alu_data;
    case (wb_sel_e'(wb_sel))
      WB_MEM:  wb_value = loaded_data;
      WB_PC4:  wb_value = pc + STEP;
      default: wb_value = alu_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Captures one result per handshake, writes the register file in the cycle
// after capture, exposes a forwarding tap and an ecall retire pulse.
// Optional feature: define MEM_WB_RETIRE_CNT_EN to add the instret counter port.
module mem_wb_stage #(
  parameter int         XLEN       = core_pkg::XLEN_DEFAULT,
  parameter int         REG_ADDR_W = core_pkg::REG_ADDR_W_DEFAULT,
  parameter logic [7:0] ECALL_ID   = core_pkg::ECALL_ID,
  parameter int         PC_STEP    = core_pkg::PC_STEP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_done,
  input  logic                  flush,
  input  logic [XLEN-1:0]       loaded_data,
  input  logic [XLEN-1:0]       alu_data,
  input  logic [XLEN-1:0]       pc,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  reg_write,
  input  logic [1:0]            wb_sel,
  input  logic [7:0]            instruction,
  output logic                  mem_wb_pipeline_valid,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  ecall_retire,
  output logic                  wb_busy
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [XLEN-1:0]       instret
`endif
);
  import core_pkg::*;

  mem_wb_state_e         state;
  mem_wb_state_e         next_state;
  logic [XLEN-1:0]       wb_value;
  logic [XLEN-1:0]       cap_data;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic                  cap_reg_write;
  logic [7:0]            cap_instr;
  logic                  capture;
  logic                  commit_ok;
  logic                  drain_exit;

  wb_result_mux #(
    .XLEN    (XLEN),
    .PC_STEP (PC_STEP)
  ) u_wb_result_mux (
    .wb_sel      (wb_sel),
    .alu_data    (alu_data),
    .loaded_data (loaded_data),
    .pc          (pc),
    .wb_value    (wb_value)
  );

  // Handshake qualifiers: capture in IDLE, commit unless squashed or reset.
  always_comb begin
    capture    = (state == IDLE) && memory_done && !flush;
    commit_ok  = (state == COMMIT) && !flush && !reset;
    drain_exit = (state == DRAIN) && !memory_done;
  end

  // Next-state: IDLE -> COMMIT on capture, COMMIT always drains, DRAIN waits for memory_done low.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture) next_state = COMMIT;
      COMMIT:  next_state = DRAIN;
      DRAIN:   if (!memory_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Captured result; cleared on return to IDLE so the forwarding tap reads zero when idle.
  always_ff @(posedge clk) begin
    if (reset || drain_exit) begin
      cap_data      <= '0;
      cap_rd        <= '0;
      cap_reg_write <= 1'b0;
      cap_instr     <= '0;
    end else if (capture) begin
      cap_data      <= wb_value;
      cap_rd        <= dest_reg;
      cap_reg_write <= reg_write;
      cap_instr     <= instruction;
    end
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wb_pipeline_valid <= 1'b0;
      wb_busy               <= 1'b0;
      fwd_valid             <= 1'b0;
      ecall_retire          <= 1'b0;
    end else begin
      mem_wb_pipeline_valid <= (next_state != IDLE);
      wb_busy               <= (next_state != IDLE);
      if (capture)
        fwd_valid <= reg_write && (dest_reg != '0);
      else if (next_state == IDLE)
        fwd_valid <= 1'b0;
      ecall_retire <= commit_ok && (cap_instr == ECALL_ID);
    end
  end

  // Register-file port decodes the state register; x0 and squashed commits never write.
  always_comb begin
    rf_we    = commit_ok && cap_reg_write && (cap_rd != '0);
    rf_waddr = (state == COMMIT) ? cap_rd : '0;
    rf_wdata = (state == COMMIT) ? cap_data : '0;
  end

  assign fwd_rd   = cap_rd;
  assign fwd_data = cap_data;

`ifdef MEM_WB_RETIRE_CNT_EN
  // Retired-instruction counter: every unsquashed commit, including x0 and non-writing ops.
  always_ff @(posedge clk) begin
    if (reset)          instret <= '0;
    else if (commit_ok) instret <= instret + XLEN'(1);
  end
`else
  // Retire counter not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage.
// Inputs change 2 time units after a rising edge; outputs are checked 1 unit later.
module tb_mem_wb_stage;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            memory_done;
  logic            flush;
  logic [XLEN-1:0] loaded_data;
  logic [XLEN-1:0] alu_data;
  logic [XLEN-1:0] pc;
  logic [RW-1:0]   dest_reg;
  logic            reg_write;
  logic [1:0]      wb_sel;
  logic [7:0]      instruction;
  logic            mem_wb_pipeline_valid;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            fwd_valid;
  logic [RW-1:0]   fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            ecall_retire;
  logic            wb_busy;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [XLEN-1:0] instret;
`endif

  int vectors    = 0;
  int miscompares = 0;

  mem_wb_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .memory_done           (memory_done),
    .flush                 (flush),
    .loaded_data           (loaded_data),
    .alu_data              (alu_data),
    .pc                    (pc),
    .dest_reg              (dest_reg),
    .reg_write             (reg_write),
    .wb_sel                (wb_sel),
    .instruction           (instruction),
    .mem_wb_pipeline_valid (mem_wb_pipeline_valid),
    .rf_we                 (rf_we),
    .rf_waddr              (rf_waddr),
    .rf_wdata              (rf_wdata),
    .fwd_valid             (fwd_valid),
    .fwd_rd                (fwd_rd),
    .fwd_data              (fwd_data),
    .ecall_retire          (ecall_retire),
    .wb_busy               (wb_busy)
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    .instret               (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; memory_done = 1'b0; flush = 1'b0;
    loaded_data = '0; alu_data = '0; pc = '0; dest_reg = '0;
    reg_write = 1'b0; wb_sel = 2'd0; instruction = 8'd0;
    step(); step();
    reset = 1'b0;
    settle();
    vectors++;
    if ({mem_wb_pipeline_valid, rf_we, fwd_valid, ecall_retire, wb_busy} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b want 00000",
               {mem_wb_pipeline_valid, rf_we, fwd_valid, ecall_retire, wb_busy});
    end
    vectors++;
    if ({rf_waddr, rf_wdata, fwd_rd, fwd_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got waddr=%0d wdata=%h fwd_rd=%0d fwd_data=%h want all 0",
               rf_waddr, rf_wdata, fwd_rd, fwd_data);
    end
    step();
  endtask

  task automatic test_alu();
    memory_done = 1'b1; alu_data = 64'h2A; dest_reg = 5'd5; wb_sel = 2'd0;
    reg_write = 1'b1; instruction = 8'd0;
    settle();
    vectors++;
    if (rf_we !== 1'b0 || mem_wb_pipeline_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL alu_capture_cycle got we=%b valid=%b want 0 0", rf_we, mem_wb_pipeline_valid);
    end
    step();
    settle();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 64'h2A}) begin
      miscompares++;
      $display("[TB] FAIL alu_write got we=%b waddr=%0d wdata=%h want 1 5 2a", rf_we, rf_waddr, rf_wdata);
    end
    vectors++;
    if ({mem_wb_pipeline_valid, wb_busy, fwd_valid, fwd_rd, fwd_data} !== {3'b111, 5'd5, 64'h2A}) begin
      miscompares++;
      $display("[TB] FAIL alu_commit_status got valid=%b busy=%b fwdv=%b fwd_rd=%0d fwd_data=%h want 1 1 1 5 2a",
               mem_wb_pipeline_valid, wb_busy, fwd_valid, fwd_rd, fwd_data);
    end
    step();
    memory_done = 1'b0;
    settle();
    vectors++;
    if ({rf_we, mem_wb_pipeline_valid} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL alu_drain got we=%b valid=%b want 0 1", rf_we, mem_wb_pipeline_valid);
    end
    step();
    settle();
    vectors++;
    if ({mem_wb_pipeline_valid, wb_busy, fwd_valid} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL alu_idle got valid=%b busy=%b fwdv=%b want 0 0 0",
               mem_wb_pipeline_valid, wb_busy, fwd_valid);
    end
  endtask

  task automatic test_load();
    memory_done = 1'b1; loaded_data = 64'hFFFF_FFFF_FFFF_FF80; alu_data = 64'h1234;
    wb_sel = 2'd1; dest_reg = 5'd10; reg_write = 1'b1;
    step();
    settle();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_FF80}) begin
      miscompares++;
      $display("[TB] FAIL load_write got we=%b waddr=%0d wdata=%h want 1 10 ffffffffffffff80",
               rf_we, rf_waddr, rf_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      vectors++;
      if ({rf_we, mem_wb_pipeline_valid} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL load_held_%0d got we=%b valid=%b want 0 1", i, rf_we, mem_wb_pipeline_valid);
      end
    end
    memory_done = 1'b0;
    step();
    settle();
    vectors++;
    if ({mem_wb_pipeline_valid, wb_busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL load_release got valid=%b busy=%b want 0 0", mem_wb_pipeline_valid, wb_busy);
    end
  endtask

  task automatic test_x0_jal();
    memory_done = 1'b1; alu_data = 64'h77; wb_sel = 2'd0; dest_reg = 5'd0; reg_write = 1'b1;
    step();
    memory_done = 1'b0;
    settle();
    vectors++;
    if ({rf_we, fwd_valid, mem_wb_pipeline_valid} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL x0_commit got we=%b fwdv=%b valid=%b want 0 0 1", rf_we, fwd_valid, mem_wb_pipeline_valid);
    end
    step(); step();
    memory_done = 1'b1; pc = 64'hFFFF_FFFF_FFFF_FFFC; wb_sel = 2'd2; dest_reg = 5'd1;
    step();
    memory_done = 1'b0;
    settle();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 64'h0}) begin
      miscompares++;
      $display("[TB] FAIL jal_wrap got we=%b waddr=%0d wdata=%h want 1 1 0", rf_we, rf_waddr, rf_wdata);
    end
    step(); step();
    memory_done = 1'b1; pc = 64'h1000; wb_sel = 2'd3; alu_data = 64'hBEEF; dest_reg = 5'd2;
    step();
    memory_done = 1'b0;
    settle();
    vectors++;
    if (rf_wdata !== 64'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL rsvd_sel got wdata=%h want beef", rf_wdata);
    end
    step(); step();
  endtask

  task automatic test_flush();
    memory_done = 1'b1; flush = 1'b1; alu_data = 64'h55; wb_sel = 2'd0; dest_reg = 5'd7; reg_write = 1'b1;
    step();
    settle();
    vectors++;
    if ({wb_busy, mem_wb_pipeline_valid, rf_we} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL flush_idle got busy=%b valid=%b we=%b want 0 0 0", wb_busy, mem_wb_pipeline_valid, rf_we);
    end
    flush = 1'b0;
    step();
    flush = 1'b1;
    settle();
    vectors++;
    if ({rf_we, mem_wb_pipeline_valid} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL flush_commit got we=%b valid=%b want 0 1", rf_we, mem_wb_pipeline_valid);
    end
    step();
    flush = 1'b0;
    settle();
    vectors++;
    if ({wb_busy, mem_wb_pipeline_valid, rf_we} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL flush_drain got busy=%b valid=%b we=%b want 1 1 0", wb_busy, mem_wb_pipeline_valid, rf_we);
    end
    memory_done = 1'b0;
    step();
    settle();
    vectors++;
    if ({wb_busy, mem_wb_pipeline_valid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL flush_exit got busy=%b valid=%b want 0 0", wb_busy, mem_wb_pipeline_valid);
    end
  endtask

  task automatic test_ecall();
    memory_done = 1'b1; instruction = 8'd57; reg_write = 1'b0; dest_reg = 5'd17;
    step();
    memory_done = 1'b0;
    settle();
    vectors++;
    if ({rf_we, ecall_retire} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL ecall_commit got we=%b retire=%b want 0 0", rf_we, ecall_retire);
    end
    step();
    settle();
    vectors++;
    if (ecall_retire !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ecall_pulse got %b want 1", ecall_retire);
    end
    step();
    settle();
    vectors++;
    if (ecall_retire !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ecall_pulse_end got %b want 0", ecall_retire);
    end
    memory_done = 1'b1;
    step();
    flush = 1'b1; memory_done = 1'b0;
    step();
    flush = 1'b0;
    settle();
    vectors++;
    if (ecall_retire !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ecall_flushed got %b want 0", ecall_retire);
    end
    step();
    instruction = 8'd0;
  endtask

  task automatic test_reset_in_commit();
    memory_done = 1'b1; alu_data = 64'h9; wb_sel = 2'd0; dest_reg = 5'd3; reg_write = 1'b1;
    step();
    reset = 1'b1; memory_done = 1'b0;
    settle();
    vectors++;
    if (rf_we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_commit_we got %b want 0", rf_we);
    end
    step();
    reset = 1'b0;
    settle();
    vectors++;
    if ({mem_wb_pipeline_valid, rf_we, fwd_valid, ecall_retire, wb_busy, rf_waddr, rf_wdata, fwd_rd, fwd_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_commit_outputs got valid=%b we=%b fwdv=%b busy=%b waddr=%0d fwd_rd=%0d fwd_data=%h want all 0",
               mem_wb_pipeline_valid, rf_we, fwd_valid, wb_busy, rf_waddr, fwd_rd, fwd_data);
    end
    step();
  endtask

`ifdef MEM_WB_RETIRE_CNT_EN
  task automatic test_instret();
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    vectors++;
    if (instret !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL instret_reset got %0d want 0", instret);
    end
    for (int i = 0; i < 3; i++) begin
      memory_done = 1'b1; dest_reg = (i == 0) ? 5'd0 : 5'd4; reg_write = (i != 2);
      step();
      memory_done = 1'b0;
      step(); step();
    end
    memory_done = 1'b1;
    step();
    flush = 1'b1; memory_done = 1'b0;
    step();
    flush = 1'b0;
    step();
    settle();
    vectors++;
    if (instret !== 64'd3) begin
      miscompares++;
      $display("[TB] FAIL instret_count got %0d want 3", instret);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_x0_jal();
    test_flush();
    test_ecall();
    test_reset_in_commit();
`ifdef MEM_WB_RETIRE_CNT_EN
    test_instret();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
